// File: rtl/pifo_reg_ctrl.sv
// pifo_reg_ctrl: register-based push-in/first-out queue of REG_WIDTH slots.
//
// An insert writes {rank, meta} into the lowest-index free slot. A remove takes
// a snapshot of all slots and reduces it through a pairwise min tree, one level
// per cycle. The entry with the lowest rank wins, and on equal ranks the lower
// slot index wins. The winner is presented on deq_* for exactly one cycle (POP),
// and its slot is freed at the end of that cycle.
//
// Optional feature: define PIFO_REG_STATS_EN to enable the 32-bit insert and
// dequeue statistics counters. When it is undefined, ins_cnt and deq_cnt are
// tied to zero.
//
// Ports
//   axis_aclk, axis_resetn          : clock, asynchronous active-low reset
//   ins_valid/ins_ready/ins_rank/ins_meta : insert handshake
//   rm_req/rm_ready                 : remove request handshake
//   deq_valid/deq_rank/deq_meta     : dequeued minimum entry (one-cycle pulse)
//   full, empty, count              : occupancy
//   ins_cnt, deq_cnt                : statistics
module pifo_reg_ctrl #(
  parameter int unsigned REG_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned META_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 3
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic [DATA_WIDTH-1:0] ins_rank,
  input  logic [META_WIDTH-1:0] ins_meta,
  input  logic                  rm_req,
  output logic                  rm_ready,
  output logic                  deq_valid,
  output logic [DATA_WIDTH-1:0] deq_rank,
  output logic [META_WIDTH-1:0] deq_meta,
  output logic                  full,
  output logic                  empty,
  output logic [IDX_WIDTH:0]    count,
  output logic [31:0]           ins_cnt,
  output logic [31:0]           deq_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [IDX_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] rank;
    logic [META_WIDTH-1:0] meta;
  } node_t;

  typedef enum logic [1:0] {StIdle, StSearch, StPop} state_e;

  localparam int unsigned LvlW = (IDX_WIDTH > 1) ? $clog2(IDX_WIDTH + 1) : 1;
  localparam logic [LvlW-1:0] LastLvl = LvlW'(IDX_WIDTH - 1);

  state_e                               state_q;
  logic [LvlW-1:0]                      lvl_q;
  logic [REG_WIDTH-1:0]                 valid_q;
  logic [REG_WIDTH-1:0][DATA_WIDTH-1:0] rank_q;
  logic [REG_WIDTH-1:0][META_WIDTH-1:0] meta_q;
  node_t [REG_WIDTH-1:0]                node_q;
  node_t [REG_WIDTH-1:0]                node_red;
  node_t [REG_WIDTH-1:0]                snap_c;
  logic                                 deq_valid_q;
  logic [DATA_WIDTH-1:0]                deq_rank_q;
  logic [META_WIDTH-1:0]                deq_meta_q;

  logic [IDX_WIDTH:0]   count_c;
  logic [IDX_WIDTH-1:0] free_idx;
  logic                 ins_fire;
  logic                 rm_fire;

  // Left operand always covers lower slot indices, so a rank tie keeps it.
  function automatic node_t pick(input node_t a, input node_t b);
    node_t r;
    if (a.valid && b.valid) begin
      r = (a.rank <= b.rank) ? a : b;
    end else if (b.valid) begin
      r = b;
    end else begin
      r = a;
    end
    return r;
  endfunction

  // Occupancy, lowest free slot and the snapshot image of the slots.
  always_comb begin
    count_c  = '0;
    free_idx = '0;
    snap_c   = '0;
    for (int i = int'(REG_WIDTH) - 1; i >= 0; i--) begin
      count_c = count_c + {{IDX_WIDTH{1'b0}}, valid_q[i]};
      if (!valid_q[i]) begin
        free_idx = IDX_WIDTH'(i);
      end
      snap_c[i].valid = valid_q[i];
      snap_c[i].idx   = IDX_WIDTH'(i);
      snap_c[i].rank  = rank_q[i];
      snap_c[i].meta  = meta_q[i];
    end
  end

  // One tree level: node i takes min(node 2i, node 2i+1). Upper nodes beyond the
  // active width become don't-care but are never read by the active ones.
  always_comb begin
    node_red = node_q;
    for (int i = 0; i < int'(REG_WIDTH / 2); i++) begin
      node_red[i] = pick(node_q[2*i], node_q[2*i+1]);
    end
  end

  assign empty     = (count_c == '0);
  assign full      = (count_c == (IDX_WIDTH + 1)'(REG_WIDTH));
  assign count     = count_c;
  assign rm_ready  = (state_q == StIdle) && !empty;
  assign rm_fire   = rm_req && rm_ready;
  assign ins_ready = (state_q == StIdle) && !full && !rm_fire;
  assign ins_fire  = ins_valid && ins_ready;

  assign deq_valid = deq_valid_q;
  assign deq_rank  = deq_rank_q;
  assign deq_meta  = deq_meta_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q     <= StIdle;
      lvl_q       <= '0;
      valid_q     <= '0;
      rank_q      <= '0;
      meta_q      <= '0;
      node_q      <= '0;
      deq_valid_q <= 1'b0;
      deq_rank_q  <= '0;
      deq_meta_q  <= '0;
    end else begin
      deq_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rm_fire) begin
            node_q  <= snap_c;
            lvl_q   <= '0;
            state_q <= StSearch;
          end else if (ins_fire) begin
            valid_q[free_idx] <= 1'b1;
            rank_q[free_idx]  <= ins_rank;
            meta_q[free_idx]  <= ins_meta;
          end
        end
        StSearch: begin
          node_q <= node_red;
          lvl_q  <= lvl_q + 1'b1;
          // The last reduction lands straight in the dequeue registers so the
          // pulse coincides with the POP cycle.
          if (lvl_q == LastLvl) begin
            state_q     <= StPop;
            deq_valid_q <= 1'b1;
            deq_rank_q  <= node_red[0].rank;
            deq_meta_q  <= node_red[0].meta;
          end
        end
        StPop: begin
          valid_q[node_q[0].idx] <= 1'b0;
          state_q                <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PIFO_REG_STATS_EN
  logic [31:0] ins_cnt_q;
  logic [31:0] deq_cnt_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      ins_cnt_q <= '0;
      deq_cnt_q <= '0;
    end else begin
      if (ins_fire) begin
        ins_cnt_q <= ins_cnt_q + 32'd1;
      end
      if (state_q == StPop) begin
        deq_cnt_q <= deq_cnt_q + 32'd1;
      end
    end
  end

  assign ins_cnt = ins_cnt_q;
  assign deq_cnt = deq_cnt_q;
`else
  assign ins_cnt = '0;
  assign deq_cnt = '0;
`endif

endmodule
